vga_plot_arbiter: RTL
=====================

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of plot requesters (index 0 = frame scan, 1 = centroid overlay, 2 = history overlay).
REQ-002 SHALL have parameter STARVE_LIMIT, default 16, consecutive denied cycles before requester 0 is promoted.
REQ-003 SHALL have parameters IMAGE_W 320 and IMAGE_H 240, the visible bounds used for clipping.
REQ-004 Port `clock`: input, 1 bit, single clock for all logic.
REQ-005 Port `reset`: input, 1 bit, asynchronous, active-high.
REQ-006 Port `req`: input, NUM_REQ bits, per-requester plot request.
REQ-007 Port `lock`: input, NUM_REQ bits, per-requester burst hold, sampled only while that requester is granted.
REQ-008 Port `req_x`: input, NUM_REQ*9 bits, packed x coordinates, requester i at bits [9i+8:9i].
REQ-009 Port `req_y`: input, NUM_REQ*8 bits, packed y coordinates.
REQ-010 Port `req_colour`: input, NUM_REQ bits, monochrome colour.
REQ-011 Port `grant`: output, NUM_REQ bits, one-hot or zero, combinational from current state and req.
REQ-012 Port `frame_start`: input, 1 bit, single-cycle pulse at vsync that clears the statistics counters.
REQ-013 Ports `vga_plot` (1), `vga_x` (9), `vga_y` (8), `vga_colour` (1): outputs, registered write port to the VGA adapter.
REQ-014 Ports `plot_count` (17) and `clip_count` (17): outputs, per-frame counts of accepted and clipped plots.

Function
REQ-015 SHALL accept a request in the cycle where req[i] and grant[i] are both 1; the requester advances its coordinates on that edge.
REQ-016 SHALL use fixed priority 2 > 1 > 0 when unlocked and no promotion is pending.
REQ-017 SHALL keep the grant on the current owner while lock[owner] and req[owner] are both 1, ignoring higher-priority requests.
REQ-018 SHALL release the lock when req[owner] drops; lock with no req holds nothing, and grant returns to priority arbitration that same cycle.
REQ-019 SHALL count, with a saturating counter, each cycle in which req[0]=1 and grant[0]=0; the counter resets when grant[0]=1.
REQ-020 When the starvation counter reaches STARVE_LIMIT and no lock is held, requester 0 SHALL win exactly one grant and the counter SHALL clear.
REQ-021 An active lock SHALL take precedence over promotion; promotion SHALL stay pending until the lock is released.
REQ-022 SHALL present an accepted request on vga_* one cycle after acceptance (latency 1); vga_plot=1 for exactly that cycle per accepted in-bounds request.
REQ-023 SHALL clip a request with x >= IMAGE_W or y >= IMAGE_H: the request is accepted (granted) but vga_plot stays 0 and clip_count increments.
REQ-024 SHALL increment plot_count for each in-bounds accepted request; both counters SHALL saturate at all-ones.
REQ-025 frame_start SHALL zero both counters; a frame_start coinciding with an accept SHALL leave the counter at 1 (the new frame counts that plot).
REQ-026 With no req asserted, vga_plot SHALL be 0; vga_x, vga_y and vga_colour SHALL hold their last values.
REQ-027 Owner state: IDLE or OWN(i); IDLE→OWN(i) on accept with lock[i]=1; OWN(i)→IDLE on req[i]=0 or lock[i]=0 at accept.

Reset
REQ-028 On reset SHALL force vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, grant=0, owner=IDLE, starvation counter=0, plot_count=0, clip_count=0.
REQ-029 Reset asserted mid-burst SHALL drop the lock; the first grant after release follows plain priority.

Structure
REQ-030 X_WIDTH (9), Y_WIDTH (8), IMAGE_W, IMAGE_H and requester index constants SHALL live in the shared project package/header.
REQ-031 The priority/starvation grant logic SHALL be one sub-module, plot_grant_select; the output register and counters stay in the top module.

Verification
REQ-032 req=3'b111, lock=0, all in-bounds → grant=3'b100; vga_plot=1 next cycle with requester 2's x/y.
REQ-033 Requester 1 locked for an 8-plot burst while req[2]=1 → grant[1] held for 8 accepts, then grant moves to requester 2.
REQ-034 req[2] and req[0] continuously high, STARVE_LIMIT=16 → grant[0]=1 in exactly one cycle after 16 denied cycles, then priority resumes.
REQ-035 Requester 0 at x=320, y=10 → granted, vga_plot=0, clip_count=1, plot_count unchanged.
REQ-036 frame_start in the same cycle as an in-bounds accept after 100 plots → plot_count=1 next cycle.
REQ-037 Reset asserted during a locked burst → all outputs 0 immediately; after release, req=3'b011 → grant=3'b010.

Source files
------------

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants and types for the VGA plot arbiter.
// Coordinate widths, visible bounds and requester indices.
package vga_plot_arbiter_pkg;

  localparam int X_WIDTH   = 9;
  localparam int Y_WIDTH   = 8;
  localparam int IMAGE_W   = 320;
  localparam int IMAGE_H   = 240;
  localparam int CNT_WIDTH = 17;

  localparam int REQ_SCAN     = 0;
  localparam int REQ_CENTROID = 1;
  localparam int REQ_HISTORY  = 2;

  typedef enum logic {
    OWN_IDLE,
    OWN_HELD
  } own_state_e;

endpackage

// File: rtl/plot_grant_select.sv
// Grant selection: burst lock, starvation promotion of the
// frame scan, then fixed priority with the highest index winning.
module plot_grant_select
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  own_state_e       own_q, own_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic             hold;
  logic             promote;
  logic             found;
  logic [IDX_W-1:0] prio_idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    hold     = (own_q == OWN_HELD) && req[owner_q];
    promote  = (starve_q == LIMIT) && req[REQ_SCAN];
    prio_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        prio_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end

    // A held lock outranks a pending promotion.
    priority case (1'b1)
      hold:    sel = owner_q;
      promote: sel = IDX_W'(REQ_SCAN);
      default: sel = prio_idx;
    endcase

    grant = '0;
    if (found && !reset) grant[sel] = 1'b1;

    own_d   = OWN_IDLE;
    owner_d = owner_q;
    if (found && lock[sel]) begin
      own_d   = OWN_HELD;
      owner_d = sel;
    end

    starve_d = starve_q;
    if (grant[REQ_SCAN]) begin
      starve_d = '0;
    end else if (req[REQ_SCAN] && starve_q != LIMIT) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_q    <= OWN_IDLE;
      owner_q  <= '0;
      starve_q <= '0;
    end else begin
      own_q    <= own_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates plot requests onto the VGA adapter write port,
// clipping off-screen pixels and keeping per-frame statistics.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 16,
  parameter int IMAGE_W      = vga_plot_arbiter_pkg::IMAGE_W,
  parameter int IMAGE_H      = vga_plot_arbiter_pkg::IMAGE_H
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           lock,
  input  logic [NUM_REQ*X_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0]   req_y,
  input  logic [NUM_REQ-1:0]           req_colour,
  output logic [NUM_REQ-1:0]           grant,
  input  logic                         frame_start,
  output logic                         vga_plot,
  output logic [X_WIDTH-1:0]           vga_x,
  output logic [Y_WIDTH-1:0]           vga_y,
  output logic                         vga_colour,
  output logic [CNT_WIDTH-1:0]         plot_count,
  output logic [CNT_WIDTH-1:0]         clip_count
);

  logic [NUM_REQ-1:0]   grant_w;
  logic [X_WIDTH-1:0]   sel_x;
  logic [Y_WIDTH-1:0]   sel_y;
  logic                 sel_c;
  logic                 accept;
  logic                 in_bounds;
  logic                 plot_hit;
  logic                 clip_hit;

  logic                 plot_q;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic                 c_q, c_d;
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] ccnt_q, ccnt_d;

  plot_grant_select #(
    .NUM_REQ     (NUM_REQ),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clock(clock),
    .reset(reset),
    .req  (req),
    .lock (lock),
    .grant(grant_w)
  );

  assign grant = grant_w;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_w[i]) begin
        sel_x = req_x[i*X_WIDTH +: X_WIDTH];
        sel_y = req_y[i*Y_WIDTH +: Y_WIDTH];
        sel_c = req_colour[i];
      end
    end
    accept    = |grant_w;
    in_bounds = (int'(sel_x) < IMAGE_W) && (int'(sel_y) < IMAGE_H);
    plot_hit  = accept && in_bounds;
    clip_hit  = accept && !in_bounds;

    x_d = x_q;
    y_d = y_q;
    c_d = c_q;
    if (plot_hit) begin
      x_d = sel_x;
      y_d = sel_y;
      c_d = sel_c;
    end

    // A frame start that coincides with an accept counts it in the new frame.
    pcnt_d = pcnt_q;
    ccnt_d = ccnt_q;
    if (frame_start) begin
      pcnt_d = CNT_WIDTH'(plot_hit);
      ccnt_d = CNT_WIDTH'(clip_hit);
    end else begin
      if (plot_hit && !(&pcnt_q)) pcnt_d = pcnt_q + CNT_WIDTH'(1);
      if (clip_hit && !(&ccnt_q)) ccnt_d = ccnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= 1'b0;
      pcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      plot_q <= plot_hit;
      x_q    <= x_d;
      y_q    <= y_d;
      c_q    <= c_d;
      pcnt_q <= pcnt_d;
      ccnt_q <= ccnt_d;
    end
  end

  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = c_q;
  assign plot_count = pcnt_q;
  assign clip_count = ccnt_q;

endmodule
